tank_motion_engine: RTL and testbench

Parametrised, clocked motion engine for up to four tanks. Replaces per-tank movement modules and the combinational sin/cos sign-fixing logic with one time-multiplexed datapath. On each VGA vertical-sync rising edge it decodes the USB keycode word, rotates each tank, and advances its fixed-point position along its heading. Outputs feed the color mapper and the collision logic.

---
 rtl/tank_pkg.sv | 49 ++++
 rtl/tank_motion_engine_rom.sv | 41 ++++
 rtl/tank_motion_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_tank_motion_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank motion engine: FSM states, key map,
// spawn positions and fixed-point widths.
package tank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROT,
        ST_LUT,
        ST_MOVE,
        ST_WRITE
    } state_t;

    localparam int POS_INT_BITS  = 12;
    localparam int POS_FRAC_BITS = 8;
    localparam int POS_W         = POS_INT_BITS + POS_FRAC_BITS;
    localparam int SCREEN_W      = 10;
    localparam int LUT_W         = 9;
    localparam int TRIG_W        = 10;
    localparam int STEP_W        = 13;

    localparam int KEY_FWD   = 0;
    localparam int KEY_BACK  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    // Rows are tanks; columns are forward / back / left / right.
    localparam logic [7:0] KEY_TABLE [4][4] = '{
        '{8'h1A, 8'h16, 8'h04, 8'h07},
        '{8'h52, 8'h51, 8'h50, 8'h4F},
        '{8'h0C, 8'h0E, 8'h0D, 8'h0F},
        '{8'h60, 8'h5D, 8'h5C, 8'h5E}
    };

    localparam logic [SCREEN_W-1:0] START_X [4] = '{10'd80, 10'd560, 10'd320, 10'd320};
    localparam logic [SCREEN_W-1:0] START_Y [4] = '{10'd240, 10'd240, 10'd80, 10'd400};

    // A zero byte means "no key" in the HID report and must never match.
    function automatic logic key_pressed(input logic [31:0] snap, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (code != 8'h00 && snap[b*8 +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/tank_motion_engine_rom.sv
// Quarter-wave sine table, Q+1 entries scaled by 256, with a registered
// dual read so sin and cos magnitudes arrive together one cycle later.
module quarter_sine_rom
    import tank_pkg::*;
#(
    parameter int ANGLE_BITS = 6
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ANGLE_BITS-2:0] addr_a,
    input  logic [ANGLE_BITS-2:0] addr_b,
    output logic [LUT_W-1:0]      data_a,
    output logic [LUT_W-1:0]      data_b
);

    localparam int Q = 2 ** (ANGLE_BITS - 2);

    function automatic logic [LUT_W-1:0] sine_entry(input int k);
        real theta;
        theta = 3.141592653589793 * real'(k) / real'(2 * Q);
        return LUT_W'($rtoi(256.0 * $sin(theta) + 0.5));
    endfunction

    logic [LUT_W-1:0] rom_q [Q+1];

    for (genvar k = 0; k <= Q; k++) begin : g_entry
        localparam logic [LUT_W-1:0] ENTRY = sine_entry(k);
        assign rom_q[k] = ENTRY;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= rom_q[addr_a];
            data_b <= rom_q[addr_b];
        end
    end

endmodule

// File: rtl/tank_motion_engine.sv
// Time-multiplexed per-frame tank update: rotate, look up heading, step along
// it in 12.8 fixed point, clamp to the play field and commit.
//
//  state | meaning
//  IDLE  | waiting for a synchronised vs rising edge
//  ROT   | apply left/right keys to the current tank heading
//  LUT   | quarter-sine ROM address presented
//  MOVE  | signed sin/cos formed, unclamped position computed
//  WRITE | clamp and commit, then next tank or back to IDLE
module tank_motion_engine
    import tank_pkg::*;
#(
    parameter int N_TANKS    = 2,
    parameter int ANGLE_BITS = 6,
    parameter int SPEED      = 2,
    parameter int X_MIN      = 16,
    parameter int X_MAX      = 623,
    parameter int Y_MIN      = 16,
    parameter int Y_MAX      = 463
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  vs,
    input  logic [31:0]           keycode,
    output logic [SCREEN_W-1:0]   tank_x     [N_TANKS],
    output logic [SCREEN_W-1:0]   tank_y     [N_TANKS],
    output logic [ANGLE_BITS-1:0] tank_angle [N_TANKS],
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            missed_frames
);

    localparam int IDX_W  = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
    localparam int Q      = 2 ** (ANGLE_BITS - 2);
    localparam int ADDR_W = ANGLE_BITS - 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_TANKS - 1);
    localparam logic [ANGLE_BITS-1:0] HALF_TURN = ANGLE_BITS'(2 ** (ANGLE_BITS - 1));
    localparam logic [ADDR_W-1:0]     Q_ADDR    = ADDR_W'(Q);

    localparam logic signed [STEP_W-1:0]       SPEED_S = STEP_W'(SPEED);
    localparam logic signed [POS_INT_BITS-1:0] X_LO    = POS_INT_BITS'(X_MIN);
    localparam logic signed [POS_INT_BITS-1:0] X_HI    = POS_INT_BITS'(X_MAX);
    localparam logic signed [POS_INT_BITS-1:0] Y_LO    = POS_INT_BITS'(Y_MIN);
    localparam logic signed [POS_INT_BITS-1:0] Y_HI    = POS_INT_BITS'(Y_MAX);

    logic vs_meta, vs_sync, vs_prev, frame_req;

    state_t state, state_nxt;

    logic [IDX_W-1:0]           idx;
    logic [31:0]                snap;
    logic [ANGLE_BITS-1:0]      work_ang;
    logic signed [POS_W-1:0]    work_x, work_y;
    logic signed [POS_W-1:0]    pos_x [N_TANKS];
    logic signed [POS_W-1:0]    pos_y [N_TANKS];
    logic [ANGLE_BITS-1:0]      ang   [N_TANKS];

    logic key_fwd, key_back, key_left, key_right;
    logic [ANGLE_BITS-1:0] rot_ang;

    logic [1:0]           quad;
    logic [ADDR_W-1:0]    addr_i, addr_qi, addr_sin, addr_cos;
    logic [LUT_W-1:0]     rom_sin, rom_cos;

    logic signed [TRIG_W-1:0] sin_mag, cos_mag, sin_v, cos_v;
    logic signed [STEP_W-1:0] sin_ext, cos_ext, dx, dy, step_x, step_y;
    logic signed [POS_W-1:0]  step_x_ext, step_y_ext;

    logic signed [POS_INT_BITS-1:0] x_int, y_int;
    logic signed [POS_W-1:0]        clamp_x, clamp_y;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vs;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign frame_req = vs_sync & ~vs_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (frame_req) state_nxt = ST_ROT;
            ST_ROT:   state_nxt = ST_LUT;
            ST_LUT:   state_nxt = ST_MOVE;
            ST_MOVE:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_ROT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        key_fwd   = key_pressed(snap, KEY_TABLE[idx][KEY_FWD]);
        key_back  = key_pressed(snap, KEY_TABLE[idx][KEY_BACK]);
        key_left  = key_pressed(snap, KEY_TABLE[idx][KEY_LEFT]);
        key_right = key_pressed(snap, KEY_TABLE[idx][KEY_RIGHT]);

        rot_ang = ang[idx];
        if (key_left && !key_right)      rot_ang = ang[idx] + 1'b1;
        else if (key_right && !key_left) rot_ang = ang[idx] - 1'b1;
    end

    // Odd quadrants read the table mirrored, so sin and cos swap addresses.
    assign quad     = work_ang[ANGLE_BITS-1 -: 2];
    assign addr_i   = ADDR_W'(work_ang[ANGLE_BITS-3:0]);
    assign addr_qi  = Q_ADDR - addr_i;
    assign addr_sin = quad[0] ? addr_qi : addr_i;
    assign addr_cos = quad[0] ? addr_i  : addr_qi;

    quarter_sine_rom #(.ANGLE_BITS(ANGLE_BITS)) u_rom (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .addr_a  (addr_sin),
        .addr_b  (addr_cos),
        .data_a  (rom_sin),
        .data_b  (rom_cos)
    );

    always_comb begin
        sin_mag = {1'b0, rom_sin};
        cos_mag = {1'b0, rom_cos};
        sin_v   = quad[1] ? -sin_mag : sin_mag;
        cos_v   = (quad[1] ^ quad[0]) ? -cos_mag : cos_mag;
        sin_ext = {{(STEP_W-TRIG_W){sin_v[TRIG_W-1]}}, sin_v};
        cos_ext = {{(STEP_W-TRIG_W){cos_v[TRIG_W-1]}}, cos_v};
        dx      = SPEED_S * cos_ext;
        dy      = -(SPEED_S * sin_ext);

        step_x = '0;
        step_y = '0;
        if (key_fwd && !key_back) begin
            step_x = dx;
            step_y = dy;
        end else if (key_back && !key_fwd) begin
            step_x = -dx;
            step_y = -dy;
        end
        step_x_ext = {{(POS_W-STEP_W){step_x[STEP_W-1]}}, step_x};
        step_y_ext = {{(POS_W-STEP_W){step_y[STEP_W-1]}}, step_y};
    end

    always_comb begin
        x_int   = work_x[POS_W-1:POS_FRAC_BITS];
        y_int   = work_y[POS_W-1:POS_FRAC_BITS];
        clamp_x = work_x;
        clamp_y = work_y;
        if (x_int < X_LO)      clamp_x = {X_LO, {POS_FRAC_BITS{1'b0}}};
        else if (x_int > X_HI) clamp_x = {X_HI, {POS_FRAC_BITS{1'b0}}};
        if (y_int < Y_LO)      clamp_y = {Y_LO, {POS_FRAC_BITS{1'b0}}};
        else if (y_int > Y_HI) clamp_y = {Y_HI, {POS_FRAC_BITS{1'b0}}};
    end

    // Heading is staged in work_ang so every output of a tank moves together at WRITE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx      <= '0;
            snap     <= '0;
            work_ang <= '0;
            work_x   <= '0;
            work_y   <= '0;
            done     <= 1'b0;
            for (int t = 0; t < N_TANKS; t++) begin
                pos_x[t] <= {2'b00, START_X[t], {POS_FRAC_BITS{1'b0}}};
                pos_y[t] <= {2'b00, START_Y[t], {POS_FRAC_BITS{1'b0}}};
                ang[t]   <= (t % 2 == 1) ? HALF_TURN : '0;
            end
        end else begin
            done <= (state == ST_WRITE) && (idx == LAST_IDX);
            case (state)
                ST_IDLE: begin
                    if (frame_req) begin
                        snap <= keycode;
                        idx  <= '0;
                    end
                end
                ST_ROT: work_ang <= rot_ang;
                ST_MOVE: begin
                    work_x <= pos_x[idx] + step_x_ext;
                    work_y <= pos_y[idx] + step_y_ext;
                end
                ST_WRITE: begin
                    pos_x[idx] <= clamp_x;
                    pos_y[idx] <= clamp_y;
                    ang[idx]   <= work_ang;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            missed_frames <= '0;
        end else if (frame_req && busy && missed_frames != 8'hFF) begin
            missed_frames <= missed_frames + 8'd1;
        end
    end

    for (genvar t = 0; t < N_TANKS; t++) begin : g_out
        assign tank_x[t]     = pos_x[t][POS_FRAC_BITS +: SCREEN_W];
        assign tank_y[t]     = pos_y[t][POS_FRAC_BITS +: SCREEN_W];
        assign tank_angle[t] = ang[t];
    end

endmodule

// File: tb/tb_tank_motion_engine.sv
// Scoreboard bench for tank_motion_engine with four tanks: directed scenarios
// plus randomized keycodes against a trigonometric reference model.
module tb_tank_motion_engine;

    localparam int N    = 4;
    localparam int AB   = 6;
    localparam int NANG = 64;
    localparam int SPD  = 2;
    localparam int XMIN = 16;
    localparam int XMAX = 623;
    localparam int YMIN = 16;
    localparam int YMAX = 463;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        vs;
    logic [31:0] keycode;
    logic [9:0]    tank_x     [N];
    logic [9:0]    tank_y     [N];
    logic [AB-1:0] tank_angle [N];
    logic        busy;
    logic        done;
    logic [7:0]  missed_frames;

    tank_motion_engine #(
        .N_TANKS(N), .ANGLE_BITS(AB), .SPEED(SPD),
        .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .vs            (vs),
        .keycode       (keycode),
        .tank_x        (tank_x),
        .tank_y        (tank_y),
        .tank_angle    (tank_angle),
        .busy          (busy),
        .done          (done),
        .missed_frames (missed_frames)
    );

    always #10 Clk = ~Clk;

    typedef struct packed {
        logic [3:0][9:0] x;
        logic [3:0][9:0] y;
        logic [3:0][5:0] a;
        logic [7:0]      missed;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int passes = 0;
    int frames_expected = 0;
    int dones_seen = 0;

    int mx [4];
    int my [4];
    int ma [4];
    int m_missed;

    int start_x [4] = '{80, 560, 320, 320};
    int start_y [4] = '{240, 240, 80, 400};
    int keys [4][4] = '{
        '{'h1A, 'h16, 'h04, 'h07},
        '{'h52, 'h51, 'h50, 'h4F},
        '{'h0C, 'h0E, 'h0D, 'h0F},
        '{'h60, 'h5D, 'h5C, 'h5E}
    };

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit pressed(input logic [31:0] kc, input int code);
        bit hit = 0;
        for (int b = 0; b < 4; b++)
            if (code != 0 && int'(kc[b*8 +: 8]) == code) hit = 1;
        return hit;
    endfunction

    function automatic int round256(input real v);
        real s = 256.0 * v;
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 4; t++) begin
            mx[t] = start_x[t] * 256;
            my[t] = start_y[t] * 256;
            ma[t] = (t % 2) * (NANG / 2);
        end
        m_missed = 0;
    endtask

    function automatic int clamp_fp(input int p, input int lo, input int hi);
        if (p < lo * 256) return lo * 256;
        if (p >= (hi + 1) * 256) return hi * 256;
        return p;
    endfunction

    task automatic model_frame(input logic [31:0] kc);
        exp_t e;
        for (int t = 0; t < N; t++) begin
            bit f, b, l, r;
            real theta;
            int c, s;
            f = pressed(kc, keys[t][0]);
            b = pressed(kc, keys[t][1]);
            l = pressed(kc, keys[t][2]);
            r = pressed(kc, keys[t][3]);
            if (l && !r) ma[t] = (ma[t] + 1) % NANG;
            else if (r && !l) ma[t] = (ma[t] + NANG - 1) % NANG;
            theta = 2.0 * 3.141592653589793 * real'(ma[t]) / real'(NANG);
            c = round256($cos(theta));
            s = round256($sin(theta));
            if (f && !b) begin
                mx[t] += SPD * c;
                my[t] -= SPD * s;
            end else if (b && !f) begin
                mx[t] -= SPD * c;
                my[t] += SPD * s;
            end
            mx[t] = clamp_fp(mx[t], XMIN, XMAX);
            my[t] = clamp_fp(my[t], YMIN, YMAX);
        end
        e = '0;
        for (int t = 0; t < N; t++) begin
            e.x[t] = 10'(mx[t] / 256);
            e.y[t] = 10'(my[t] / 256);
            e.a[t] = 6'(ma[t]);
        end
        e.missed = 8'(m_missed);
        sb_q.push_back(e);
        frames_expected++;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        vs = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic frame(input logic [31:0] kc);
        keycode = kc;
        model_frame(kc);
        vs = 1'b1;
        repeat (2) @(negedge Clk);
        vs = 1'b0;
        repeat (28) @(negedge Clk);
    endtask

    // Monitor: pops the scoreboard whenever the engine signals a finished frame.
    int  busy_cnt = 0;
    bit  prev_busy = 0;
    initial begin
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                busy_cnt  = 0;
                prev_busy = 0;
            end else begin
                if (busy) busy_cnt++;
                else if (busy_cnt > 0) begin
                    check("busy_len", busy_cnt, 4 * N);
                    busy_cnt = 0;
                end
                if (done) begin
                    dones_seen++;
                    check("done_after_busy", int'(prev_busy), 1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_empty: done pulse with no expected frame pending");
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        for (int t = 0; t < N; t++) begin
                            check($sformatf("x%0d", t), int'(tank_x[t]), int'(e.x[t]));
                            check($sformatf("y%0d", t), int'(tank_y[t]), int'(e.y[t]));
                            check($sformatf("ang%0d", t), int'(tank_angle[t]), int'(e.a[t]));
                        end
                        check("missed", int'(missed_frames), int'(e.missed));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        logic [31:0] kc;
        int pool [16];
        Reset_n = 1'b0;
        vs = 1'b0;
        keycode = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check("rst_x0", int'(tank_x[0]), 80);
        check("rst_y0", int'(tank_y[0]), 240);
        check("rst_a0", int'(tank_angle[0]), 0);
        check("rst_x1", int'(tank_x[1]), 560);
        check("rst_a1", int'(tank_angle[1]), 32);
        check("rst_y3", int'(tank_y[3]), 400);
        check("rst_a3", int'(tank_angle[3]), 32);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_missed", int'(missed_frames), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 10; i++) frame(32'h1A000000);
        check("fwd10_x0", int'(tank_x[0]), 100);
        check("fwd10_y0", int'(tank_y[0]), 240);
        check("fwd10_x1", int'(tank_x[1]), 560);

        do_reset();
        for (int i = 0; i < 16; i++) frame(32'h00000004);
        frame(32'h1A000000);
        check("a90_ang", int'(tank_angle[0]), 16);
        check("a90_x", int'(tank_x[0]), 80);
        check("a90_y", int'(tank_y[0]), 238);

        do_reset();
        for (int i = 0; i < 8; i++) frame(32'h04000000);
        frame(32'h001A0000);
        check("a45_x", int'(tank_x[0]), 81);
        check("a45_y", int'(tank_y[0]), 238);
        frame(32'h1A000000);
        check("a45_x2", int'(tank_x[0]), 82);

        do_reset();
        frame(32'h07000000);
        check("wrap_ang", int'(tank_angle[0]), 63);

        do_reset();
        for (int i = 0; i < 40; i++) frame(32'h16000000);
        check("clamp_x", int'(tank_x[0]), 16);

        do_reset();
        keycode = 32'h1A000000;
        m_missed++;
        model_frame(32'h1A000000);
        vs = 1'b1;
        repeat (2) @(negedge Clk);
        vs = 1'b0;
        repeat (3) @(negedge Clk);
        vs = 1'b1;
        repeat (2) @(negedge Clk);
        vs = 1'b0;
        repeat (30) @(negedge Clk);
        check("dbl_missed", int'(missed_frames), 1);
        check("dbl_x0", int'(tank_x[0]), 82);

        do_reset();
        frame(32'h1A520000);
        check("both_x0", int'(tank_x[0]), 82);
        check("both_x1", int'(tank_x[1]), 558);

        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 4; k++) pool[t*4 + k] = keys[t][k];
        for (int i = 0; i < 60; i++) begin
            for (int b = 0; b < 4; b++) begin
                case ($urandom_range(0, 3))
                    0:       kc[b*8 +: 8] = 8'h00;
                    1:       kc[b*8 +: 8] = 8'($urandom_range(0, 255));
                    default: kc[b*8 +: 8] = 8'(pool[$urandom_range(0, 15)]);
                endcase
            end
            frame(kc);
        end

        keycode = 32'h1A520C60;
        vs = 1'b1;
        repeat (8) @(negedge Clk);
        Reset_n = 1'b0;
        vs = 1'b0;
        model_reset();
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_x0", int'(tank_x[0]), 80);
        check("abort_y2", int'(tank_y[2]), 80);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (30) @(negedge Clk);
        check("abort_idle", int'(busy), 0);

        check("done_count", dones_seen, frames_expected);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
